// File: rtl/ysyx_25030081_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25030081_mem_arbiter
// Brief    : Shares one data-memory port between the IFU (fetch) and the LSU
//            (load/store). It runs one transaction at a time, with round-robin
//            grant, byte-lane/wmask alignment, load extension, misalignment and
//            illegal-op detection, and a response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25030081_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // IFU side
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
  output logic                  ifu_rsp_valid,
  input  logic                  ifu_rsp_ready,
  output logic [DATA_WIDTH-1:0] ifu_rsp_data,
  output logic                  ifu_rsp_err,
  // LSU side
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_req_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
  input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
  input  logic [2:0]            lsu_req_op,
  output logic                  lsu_rsp_valid,
  input  logic                  lsu_rsp_ready,
  output logic [DATA_WIDTH-1:0] lsu_rsp_rdata,
  output logic                  lsu_rsp_err,
  // Memory side
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // WAIT gives up once the counter has spent TIMEOUT cycles, i.e. on the
  // cycle where it holds TIMEOUT-1.
  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

  state_t                r_state;
  logic                  r_last_lsu;   // 1: LSU won the last grant
  logic                  r_owner_lsu;  // owner of the transaction in flight
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wen;
  logic [DATA_WIDTH-1:0] r_wdata;      // already lane-shifted
  logic [3:0]            r_wmask;      // already lane-shifted
  logic [2:0]            r_op;
  logic [7:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_pick_lsu;
  logic                  w_grant;
  logic [ADDR_WIDTH-1:0] w_g_addr;
  logic [2:0]            w_g_op;
  logic                  w_g_wen;
  logic [DATA_WIDTH-1:0] w_g_wdata;
  logic                  w_illegal;
  logic                  w_misalign;
  logic [3:0]            w_mask_base;
  logic [3:0]            w_g_mask;
  logic [DATA_WIDTH-1:0] w_g_wdata_sh;
  logic [DATA_WIDTH-1:0] w_rsh;
  logic [DATA_WIDTH-1:0] w_load;
  logic                  w_rsp_ready;

  // Round-robin pick: on a tie, whoever did not win last time goes first.
  assign w_pick_lsu = lsu_req_valid && (!ifu_req_valid || !r_last_lsu);
  assign w_grant    = (r_state == S_IDLE) && (ifu_req_valid || lsu_req_valid);

  assign ifu_req_ready = rst_n && w_grant && !w_pick_lsu;
  assign lsu_req_ready = rst_n && w_grant &&  w_pick_lsu;

  // Fields of the request being granted; IFU fetches are plain word loads.
  assign w_g_addr  = w_pick_lsu ? lsu_req_addr  : ifu_req_addr;
  assign w_g_op    = w_pick_lsu ? lsu_req_op    : 3'b010;
  assign w_g_wen   = w_pick_lsu && lsu_req_wen;
  assign w_g_wdata = w_pick_lsu ? lsu_req_wdata : '0;

  assign w_illegal  = (w_g_op == 3'b011) || (w_g_op == 3'b110) || (w_g_op == 3'b111);
  assign w_misalign = ((w_g_op[1:0] == 2'b01) && w_g_addr[0]) ||
                      ((w_g_op[1:0] == 2'b10) && (w_g_addr[1:0] != 2'b00));

  // Byte-lane alignment of store data and write mask.
  always_comb begin
    w_mask_base = 4'b1111;
    case (w_g_op[1:0])
      2'b00:   w_mask_base = 4'b0001;
      2'b01:   w_mask_base = 4'b0011;
      default: w_mask_base = 4'b1111;
    endcase
  end
  assign w_g_mask     = w_g_wen ? (w_mask_base << w_g_addr[1:0]) : 4'b0000;
  assign w_g_wdata_sh = w_g_wdata << {w_g_addr[1:0], 3'b000};

  // Load extraction: bring the addressed lane down, then extend by op.
  assign w_rsh = mem_rsp_rdata >> {r_addr[1:0], 3'b000};
  always_comb begin
    w_load = w_rsh;
    case (r_op)
      3'b000:  w_load = {{24{w_rsh[7]}},  w_rsh[7:0]};
      3'b100:  w_load = {24'h0,           w_rsh[7:0]};
      3'b001:  w_load = {{16{w_rsh[15]}}, w_rsh[15:0]};
      3'b101:  w_load = {16'h0,           w_rsh[15:0]};
      default: w_load = w_rsh;
    endcase
    if (r_wen) begin
      w_load = '0;
    end
  end

  assign w_rsp_ready = r_owner_lsu ? lsu_rsp_ready : ifu_rsp_ready;

  // Transaction FSM: grant, memory handshake, timeout and response hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last_lsu  <= 1'b0;
      r_owner_lsu <= 1'b0;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= 4'b0000;
      r_op        <= 3'b000;
      r_cnt       <= 8'd0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_last_lsu  <= w_pick_lsu;
            r_owner_lsu <= w_pick_lsu;
            r_addr      <= w_g_addr;
            r_wen       <= w_g_wen;
            r_wdata     <= w_g_wdata_sh;
            r_wmask     <= w_g_mask;
            r_op        <= w_g_op;
            if (w_illegal || w_misalign) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            r_cnt   <= 8'd0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response arriving on the timeout cycle still wins.
          if (mem_rsp_valid) begin
            r_rdata <= w_load;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (r_cnt == c_tmo_last) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (w_rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory request fields are only driven while the request is presented.
  assign mem_req_valid = (r_state == S_REQ);
  assign mem_addr      = mem_req_valid ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wen       = mem_req_valid && r_wen;
  assign mem_wdata     = mem_req_valid ? r_wdata : '0;
  assign mem_wmask     = mem_req_valid ? r_wmask : 4'b0000;

  // Responses go only to the requester that owns the transaction.
  assign ifu_rsp_valid = (r_state == S_RESP) && !r_owner_lsu;
  assign lsu_rsp_valid = (r_state == S_RESP) &&  r_owner_lsu;
  assign ifu_rsp_data  = ifu_rsp_valid ? r_rdata : '0;
  assign ifu_rsp_err   = ifu_rsp_valid && r_err;
  assign lsu_rsp_rdata = lsu_rsp_valid ? r_rdata : '0;
  assign lsu_rsp_err   = lsu_rsp_valid && r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25030081_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25030081_mem_arbiter
// Brief    : Directed self-checking bench for the IFU/LSU memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25030081_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [31:0] ifu_req_addr, ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
  logic [2:0]  lsu_req_op;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_rdata;
  logic [3:0]  mem_wmask;

  int n_total = 0;
  int n_bad   = 0;

  ysyx_25030081_mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (8)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr (ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_data (ifu_rsp_data),
    .ifu_rsp_err  (ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .lsu_req_wen  (lsu_req_wen),
    .lsu_req_addr (lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata),
    .lsu_req_op   (lsu_req_op),
    .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rsp_ready(lsu_rsp_ready),
    .lsu_rsp_rdata(lsu_rsp_rdata),
    .lsu_rsp_err  (lsu_rsp_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never settles.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One full memory transaction with an immediate accept and one-cycle response.
  task automatic run_txn(input string tag, input logic iv, input logic lv, input logic lwen,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] op,
                         input logic exp_lsu, input logic [31:0] e_addr, input logic [3:0] e_mask,
                         input logic [31:0] e_wdata, input logic [31:0] mrd, input logic [31:0] e_rd);
    @(negedge clk);
    ifu_req_valid = iv;  ifu_req_addr = addr;
    lsu_req_valid = lv;  lsu_req_wen = lwen; lsu_req_addr = addr;
    lsu_req_wdata = wdata; lsu_req_op = op;
    #1;
    check({tag, "_ready"}, {30'b0, ifu_req_ready, lsu_req_ready}, exp_lsu ? 32'd1 : 32'd2);
    @(negedge clk);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    #1;
    check({tag, "_mreqv"}, mem_req_valid, 1);
    check({tag, "_maddr"}, mem_addr, e_addr);
    check({tag, "_mwen"},  mem_wen, (lwen && exp_lsu) ? 32'd1 : 32'd0);
    check({tag, "_mmask"}, mem_wmask, e_mask);
    check({tag, "_mwdat"}, mem_wdata, e_wdata);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = mrd;
    #1;
    check({tag, "_mreqv_off"}, mem_req_valid, 0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    check({tag, "_rspv"}, {30'b0, ifu_rsp_valid, lsu_rsp_valid}, exp_lsu ? 32'd1 : 32'd2);
    check({tag, "_rdata"}, exp_lsu ? lsu_rsp_rdata : ifu_rsp_data, e_rd);
    check({tag, "_err"}, {30'b0, ifu_rsp_err, lsu_rsp_err}, 0);
    lsu_rsp_ready = exp_lsu; ifu_rsp_ready = !exp_lsu;
    @(negedge clk);
    lsu_rsp_ready = 1'b0; ifu_rsp_ready = 1'b0;
    #1;
    check({tag, "_rspv_off"}, {30'b0, ifu_rsp_valid, lsu_rsp_valid}, 0);
  endtask

  // LSU request that must be rejected without touching memory.
  task automatic run_err(input string tag, input logic lwen, input logic [31:0] addr,
                         input logic [2:0] op);
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_req_wen = lwen; lsu_req_addr = addr;
    lsu_req_wdata = 32'hFFFF_FFFF; lsu_req_op = op;
    #1;
    check({tag, "_ready"}, lsu_req_ready, 1);
    @(negedge clk);
    lsu_req_valid = 1'b0;
    #1;
    check({tag, "_mreqv"}, mem_req_valid, 0);
    check({tag, "_rspv"}, lsu_rsp_valid, 1);
    check({tag, "_err"}, lsu_rsp_err, 1);
    check({tag, "_rdata"}, lsu_rsp_rdata, 0);
    lsu_rsp_ready = 1'b1;
    @(negedge clk);
    lsu_rsp_ready = 1'b0;
    #1;
    check({tag, "_rspv_off"}, lsu_rsp_valid, 0);
  endtask

  // Present an LSU lw and let memory accept it; returns in the first WAIT cycle.
  task automatic start_lw(input string tag, input logic [31:0] addr);
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = addr; lsu_req_op = 3'b010;
    #1;
    check({tag, "_ready"}, lsu_req_ready, 1);
    @(negedge clk);
    lsu_req_valid = 1'b0;
    #1;
    check({tag, "_mreqv"}, mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; ifu_rsp_ready = 1'b0;
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h8000_0000;
    lsu_req_wdata = 32'h0; lsu_req_op = 3'b010; lsu_rsp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;

    // Reset state with both requesters pushing
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", {30'b0, ifu_req_ready, lsu_req_ready}, 0);
    check("rst_rspv", {30'b0, ifu_rsp_valid, lsu_rsp_valid}, 0);
    check("rst_mreqv", mem_req_valid, 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_mmask", mem_wmask, 0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with both requesting: LSU, IFU, LSU
    run_txn("arb1", 1, 1, 0, 32'h8000_0004, 32'h0, 3'b010, 1, 32'h8000_0004, 4'b0000, 32'h0,
            32'h0102_0304, 32'h0102_0304);
    run_txn("arb2", 1, 1, 0, 32'h8000_0004, 32'h0, 3'b010, 0, 32'h8000_0004, 4'b0000, 32'h0,
            32'hAABB_CCDD, 32'hAABB_CCDD);
    run_txn("arb3", 1, 1, 0, 32'h8000_0004, 32'h0, 3'b010, 1, 32'h8000_0004, 4'b0000, 32'h0,
            32'h5566_7788, 32'h5566_7788);

    // Loads with lane extraction and extension
    run_txn("lb", 0, 1, 0, 32'h8000_0003, 32'h0, 3'b000, 1, 32'h8000_0000, 4'b0000, 32'h0,
            32'h8012_3456, 32'hFFFF_FF80);
    run_txn("lh", 0, 1, 0, 32'h8000_0002, 32'h0, 3'b001, 1, 32'h8000_0000, 4'b0000, 32'h0,
            32'h8001_1234, 32'hFFFF_8001);
    run_txn("lbu", 0, 1, 0, 32'h8000_0001, 32'h0, 3'b100, 1, 32'h8000_0000, 4'b0000, 32'h0,
            32'h0000_F000, 32'h0000_00F0);
    run_txn("lhu", 0, 1, 0, 32'h8000_0002, 32'h0, 3'b101, 1, 32'h8000_0000, 4'b0000, 32'h0,
            32'h9ABC_0000, 32'h0000_9ABC);

    // Stores: lane-shifted data, mask, ack with zero rdata
    run_txn("sh", 0, 1, 1, 32'h8000_0002, 32'h1234_ABCD, 3'b001, 1, 32'h8000_0000, 4'b1100,
            32'hABCD_0000, 32'h1234_5678, 32'h0);
    run_txn("sb", 0, 1, 1, 32'h8000_0001, 32'h0000_00AA, 3'b000, 1, 32'h8000_0000, 4'b0010,
            32'h0000_AA00, 32'h1234_5678, 32'h0);
    run_txn("sw", 0, 1, 1, 32'h8000_0008, 32'hDEAD_BEEF, 3'b010, 1, 32'h8000_0008, 4'b1111,
            32'hDEAD_BEEF, 32'h1234_5678, 32'h0);

    // Misaligned and illegal requests
    run_err("mis_lw", 0, 32'h8000_0001, 3'b010);
    run_err("mis_sh", 1, 32'h8000_0003, 3'b001);
    run_err("ill_111", 0, 32'h8000_0000, 3'b111);
    run_err("ill_011", 0, 32'h8000_0000, 3'b011);

    // Timeout: memory never answers, error after 8 WAIT cycles
    start_lw("tmo", 32'h8000_0010);
    n = 0;
    #1;
    while (!lsu_rsp_valid && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("tmo_cycles", n, 8);
    check("tmo_err", lsu_rsp_err, 1);
    check("tmo_rdata", lsu_rsp_rdata, 0);
    lsu_rsp_ready = 1'b1;
    @(negedge clk);
    lsu_rsp_ready = 1'b0;
    #1;
    check("tmo_idle", {31'b0, lsu_rsp_valid}, 0);

    // Response on the last WAIT cycle beats the timeout
    start_lw("race", 32'h8000_0014);
    repeat (7) @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1122_3344;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    check("race_rspv", lsu_rsp_valid, 1);
    check("race_err", lsu_rsp_err, 0);
    check("race_rdata", lsu_rsp_rdata, 32'h1122_3344);
    lsu_rsp_ready = 1'b1;
    @(negedge clk);
    lsu_rsp_ready = 1'b0;

    // Reset in WAIT, then a stray memory response
    start_lw("rstw", 32'h8000_0020);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h7777_7777;
    #1;
    check("rstw_mreqv", mem_req_valid, 0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    check("rstw_rspv1", {30'b0, ifu_rsp_valid, lsu_rsp_valid}, 0);
    @(negedge clk);
    #1;
    check("rstw_rspv2", {30'b0, ifu_rsp_valid, lsu_rsp_valid}, 0);
    run_txn("post_rst", 1, 0, 0, 32'h8000_0100, 32'h0, 3'b010, 0, 32'h8000_0100, 4'b0000,
            32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    // last_grant was reset to IFU, so the LSU wins this tie
    run_txn("post_rst_tie", 1, 1, 0, 32'h8000_0104, 32'h0, 3'b010, 1, 32'h8000_0104, 4'b0000,
            32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
